input_conditioner: RTL

- Conditions a raw, asynchronous, possibly bouncing single-bit input, such as a push-button or external toggle line.
- Produces a clean registered level, one-cycle edge pulses and a toggle output.
- Sits directly upstream of the flip-flop stages:
  - level_out drives a D stage's data input.
  - rise_pulse serves as the T input of a toggle stage.
  - toggle_q provides a ready-made T-flip-flop result.

---
 rtl/input_conditioner.sv | 113 +++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects a raw asynchronous single-bit input.
// Outputs a clean registered level, one-cycle rise/fall pulses and a toggle bit.
module input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle_q,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_c;
    logic [CNT_W-1:0]       cnt_inc_c;
    logic                   done_c;
    logic                   level_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   toggle_d;
    logic                   busy_d;

    assign s_c       = sync_q[SYNC_STAGES-1];
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    // IDLE states hold cnt at 0, so the same test covers DEBOUNCE_CYCLES=1 straight from IDLE.
    assign done_c    = (cnt_inc_c == CNT_W'(DEBOUNCE_CYCLES));

    // Synchronizer chain plus state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= IDLE_LOW;
            cnt_q      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            toggle_q   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_out  <= level_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            toggle_q   <= toggle_d;
            busy       <= busy_d;
        end
    end

    // Next-state: count consecutive samples that disagree with the current level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE_LOW, WAIT_HIGH: begin
                if (!s_c) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (done_c) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    state_d = WAIT_HIGH;
                    cnt_d   = cnt_inc_c;
                end
            end
            IDLE_HIGH, WAIT_LOW: begin
                if (s_c) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (done_c) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else begin
                    state_d = WAIT_LOW;
                    cnt_d   = cnt_inc_c;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values, all derived from the upcoming state.
    always_comb begin
        level_d  = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
        rise_d   = level_d && !level_out;
        fall_d   = !level_d && level_out;
        busy_d   = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
        toggle_d = toggle_q ^ rise_pulse;
    end

endmodule
